// File: rtl/sram_responder_pkg.sv
// Shared constants and helpers for the SRAM responder: opcode encoding, default map, lane geometry.
// Pure definitions; no latency or flow control lives here.
package sram_responder_pkg;

  localparam logic [3:0]  SRAM_WE_READ        = 4'h0;
  localparam logic [31:0] ADDR_BASE_DEFAULT   = 32'h1C00_0000;
  localparam int unsigned DEPTH_WORDS_DEFAULT = 1024;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned WORD_W    = BYTE_W * NUM_LANES;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic rd;
    logic wr;
    logic oor;
    logic misalign;
  } req_ev_t;

  function automatic logic [7:0] err_cnt_sat_inc(input logic [7:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/sram_bytemem.sv
// Word array with per-byte write enables and a registered read port; read data holds between reads.
// One-cycle read latency; never stalls, caller guarantees at most one access per cycle.
module sram_bytemem
  import sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [NUM_LANES-1:0] wr_be,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_W-1:0]    wr_dat,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  output logic [WORD_W-1:0]    rd_dat
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rd_dat_d;
  logic [WORD_W-1:0] rd_dat_q;

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_be[i]) begin
          mem_q[addr][i*BYTE_W +: BYTE_W] <= wr_dat[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_zero) begin
      rd_dat_d = '0;
    end else if (rd_en) begin
      rd_dat_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sram_responder.sv
// Always-ready SRAM slave: decodes byte addresses into a word array, tracks errors and access counts.
// Read data one cycle after the request; no backpressure, every sram_en cycle is accepted.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic        err_clr,
  output logic        err_oor,
  output logic        err_misalign,
  output logic [7:0]  err_cnt,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] addr_off;
  logic [31:0] word_idx;
  logic        in_range;
  logic        is_read;
  req_ev_t     ev;

  logic        err_oor_d, err_oor_q;
  logic        err_mis_d, err_mis_q;
  logic [7:0]  err_cnt_d, err_cnt_q;
  logic [31:0] rd_cnt_d, rd_cnt_q;
  logic [31:0] wr_cnt_d, wr_cnt_q;

  // Below-base addresses wrap to huge indices, but the explicit compare keeps intent obvious.
  assign addr_off = sram_addr - ADDR_BASE;
  assign word_idx = addr_off >> 2;
  assign in_range = (sram_addr >= ADDR_BASE) && (word_idx < DEPTH_WORDS);
  assign is_read  = (sram_we == SRAM_WE_READ);

  always_comb begin
    ev          = '0;
    ev.rd       = sram_en && in_range && is_read;
    ev.wr       = sram_en && in_range && !is_read;
    ev.oor      = sram_en && !in_range;
    ev.misalign = sram_en && (sram_addr[1:0] != 2'b00);
  end

  // Clear first, then let a same-cycle error event win.
  always_comb begin
    err_oor_d = err_oor_q;
    err_mis_d = err_mis_q;
    err_cnt_d = err_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;

    if (err_clr) begin
      err_oor_d = 1'b0;
      err_mis_d = 1'b0;
      err_cnt_d = 8'd0;
    end
    if (ev.oor) begin
      err_oor_d = 1'b1;
      err_cnt_d = err_cnt_sat_inc(err_cnt_d);
    end
    if (ev.misalign) begin
      err_mis_d = 1'b1;
    end
    if (ev.rd) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (ev.wr) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_oor_q <= 1'b0;
      err_mis_q <= 1'b0;
      err_cnt_q <= 8'd0;
      rd_cnt_q  <= 32'd0;
      wr_cnt_q  <= 32'd0;
    end else begin
      err_oor_q <= err_oor_d;
      err_mis_q <= err_mis_d;
      err_cnt_q <= err_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // The array has no reset, so writes must be blocked explicitly while reset is held.
  sram_bytemem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (ev.wr && !reset),
    .wr_be   (sram_we),
    .addr    (word_idx[AW-1:0]),
    .wr_dat  (sram_wdata),
    .rd_en   (ev.rd),
    .rd_zero (ev.oor && is_read),
    .rd_dat  (sram_rdata)
  );

  assign err_oor      = err_oor_q;
  assign err_misalign = err_mis_q;
  assign err_cnt      = err_cnt_q;
  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized and directed checks of sram_responder against a byte-addressed reference model.
module tb_sram_responder;

  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        err_clr;
  logic        err_oor;
  logic        err_misalign;
  logic [7:0]  err_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int total = 0;
  int bad   = 0;

  bit [31:0] m_mem [DEPTH];
  bit [31:0] m_rdata, m_rd, m_wr;
  bit        m_oor, m_mis;
  int        m_cnt;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .err_clr(err_clr), .err_oor(err_oor), .err_misalign(err_misalign),
    .err_cnt(err_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rdata"}, sram_rdata, m_rdata);
    chk({tag, ".oor"}, 32'(err_oor), 32'(m_oor));
    chk({tag, ".mis"}, 32'(err_misalign), 32'(m_mis));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
    chk({tag, ".rd_cnt"}, rd_cnt, m_rd);
    chk({tag, ".wr_cnt"}, wr_cnt, m_wr);
  endtask

  task automatic model_reset();
    m_rdata = 0; m_oor = 0; m_mis = 0; m_cnt = 0; m_rd = 0; m_wr = 0;
  endtask

  // Whole-number view of the map: byte address a hits word (a-BASE)/4 when that lies in [0,DEPTH).
  task automatic model(input bit en, input bit [3:0] we, input bit [31:0] a,
                       input bit [31:0] wd, input bit clr);
    longint la, lb;
    bit     inr;
    int     idx;
    la  = longint'(a);
    lb  = longint'(BASE);
    inr = (la >= lb) && ((la - lb) / 4 < DEPTH);
    idx = inr ? int'((la - lb) / 4) : 0;
    if (clr) begin m_oor = 0; m_mis = 0; m_cnt = 0; end
    if (en) begin
      if (a % 4 != 0) m_mis = 1;
      if (!inr) begin
        m_oor = 1;
        if (m_cnt < 255) m_cnt++;
        if (we == 0) m_rdata = 0;
      end else if (we == 0) begin
        m_rdata = m_mem[idx];
        m_rd++;
      end else begin
        for (int b = 0; b < 4; b++)
          if (we[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
        m_wr++;
      end
    end
  endtask

  task automatic req(input string tag, input bit en, input bit [3:0] we, input bit [31:0] a,
                     input bit [31:0] wd, input bit clr);
    sram_en = en; sram_we = we; sram_addr = a; sram_wdata = wd; err_clr = clr;
    @(posedge clk); #1;
    model(en, we, a, wd, clr);
    sram_en = 0; err_clr = 0;
    chk_all(tag);
  endtask

  initial begin
    bit [31:0] a, saved, old;
    bit [3:0]  we;

    reset = 1; sram_en = 0; sram_we = 0; sram_addr = 0; sram_wdata = 0; err_clr = 0;
    model_reset();
    #1;
    chk_all("reset");
    @(posedge clk); #1;
    reset = 0;

    // Fill the array so every later read has a known value.
    for (int i = 0; i < DEPTH; i++) begin
      sram_en = 1; sram_we = 4'hF; sram_addr = BASE + 32'(i * 4); sram_wdata = $urandom;
      @(posedge clk); #1;
      model(1, 4'hF, sram_addr, sram_wdata, 0);
    end
    sram_en = 0;
    chk_all("fill");

    // Write then back-to-back read.
    req("wr_deadbeef", 1, 4'hF, BASE, 32'hDEADBEEF, 0);
    req("rd_deadbeef", 1, 4'h0, BASE, 0, 0);
    chk("deadbeef.const", sram_rdata, 32'hDEADBEEF);

    // Byte-lane merge.
    req("pre_11223344", 1, 4'hF, BASE + 32'h10, 32'h11223344, 0);
    req("wr_be0101", 1, 4'b0101, BASE + 32'h10, 32'hAABBCCDD, 0);
    req("rd_merge", 1, 4'h0, BASE + 32'h10, 0, 0);
    chk("merge.const", sram_rdata, 32'h11BB33DD);

    // Out-of-range at both edges of the window.
    req("oor_top", 1, 4'h0, BASE + 32'h1000, 0, 0);
    chk("oor_top.cnt", 32'(err_cnt), 32'd1);
    req("oor_below", 1, 4'h0, BASE - 32'd4, 0, 0);
    chk("oor_below.cnt", 32'(err_cnt), 32'd2);
    req("last_word", 1, 4'h0, BASE + 32'(DEPTH*4 - 4), 0, 0);

    // Misaligned read returns the containing word; idle clear drops flags.
    req("misalign", 1, 4'h0, BASE + 32'h6, 0, 0);
    chk("misalign.flag", 32'(err_misalign), 32'd1);
    req("clr", 0, 4'h0, 0, 0, 1);
    chk("clr.cnt", 32'(err_cnt), 32'd0);

    // Saturation, then clear colliding with an error.
    for (int i = 0; i < 300; i++) req("sat", 1, 4'($urandom_range(0, 15)), BASE + 32'h2000 + 32'(i), 0, 0);
    chk("sat.const", 32'(err_cnt), 32'hFF);
    req("clr_vs_err", 1, 4'hF, BASE - 32'd8, 32'h5555AAAA, 1);
    chk("clr_vs_err.cnt", 32'(err_cnt), 32'd1);

    // Read data holds through idles (with noisy inputs) and a write.
    req("hold_rd", 1, 4'h0, BASE + 32'h40, 0, 0);
    saved = sram_rdata;
    for (int i = 0; i < 5; i++) req("hold_idle", 0, 4'($urandom), $urandom, $urandom, 0);
    req("hold_wr", 1, 4'hF, BASE + 32'h40, 32'hCAFEF00D, 0);
    chk("hold.const", sram_rdata, saved);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: a = BASE + 32'($urandom_range(0, DEPTH-1) * 4);
        3:       a = BASE + 32'($urandom_range(0, DEPTH-1) * 4) + 32'($urandom_range(1, 3));
        4:       a = BASE + 32'(DEPTH*4) + 32'($urandom_range(0, 64));
        5:       a = BASE - 32'd1 - 32'($urandom_range(0, 64));
        default: a = $urandom;
      endcase
      we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      req("rand", $urandom_range(0, 3) != 0, we, a, $urandom, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-stream; a request held during reset is dropped.
    old = m_mem[7];
    req("pre_rst_rd", 1, 4'h0, BASE + 32'h4, 0, 0);
    sram_en = 1; sram_we = 4'hF; sram_addr = BASE + 32'h1C; sram_wdata = ~old;
    reset = 1;
    #1;
    model_reset();
    chk_all("rst_async");
    @(posedge clk); #1;
    chk_all("rst_held");
    sram_en = 0;
    reset = 0;
    req("post_rst_rd", 1, 4'h0, BASE + 32'h1C, 0, 0);
    chk("post_rst.retained", sram_rdata, old);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
